// File: rtl/apb_xfer_scheduler.sv
// apb_xfer_scheduler: arbitrates one pending write burst and one pending read
// burst onto a single APB master port and walks each burst beat by beat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a burst request; round-robin grant on a tie
// WWAIT  | write burst: waiting for the next beat of write data
// SETUP  | APB setup phase (psel up, penable low) or decode-miss beat
// ACCESS | APB access phase, held until pready_i
// RHOLD  | read beat presented to the front-end until rdata_ready_i
// DONE   | write burst complete, status reported for one cycle
module apb_xfer_scheduler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE = 32'h0001_F000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE = 32'h0002_F000,
    parameter logic [ADDR_WIDTH-1:0] SLV_SIZE  = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [3:0]            wr_len_i,
    input  logic [1:0]            wr_burst_i,
    output logic                  wr_gnt_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    output logic                  wr_done_o,
    output logic                  wr_err_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [3:0]            rd_len_i,
    input  logic [1:0]            rd_burst_i,
    output logic                  rd_gnt_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  rdata_last_o,
    output logic                  rdata_err_o,
    input  logic                  rdata_ready_i,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  penable_o,
    output logic [1:0]            psel_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, RHOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            cnt_q;
    logic                  incr_q;
    logic                  dir_wr_q;
    logic                  last_rd_q;
    logic                  werr_q;
    logic                  rerr_q;

    logic                  take_wr, take_rd, wbeat_load, rd_cap;
    logic                  wr_resp, wr_resp_err, beat_adv, done_clr;

    // Region decode on the current beat address. Modular subtraction keeps the
    // range test correct even for bases near the top of the address space;
    // slave 1 is masked by slave 0 so psel can never be two-hot.
    logic [ADDR_WIDTH-1:0] off0, off1;
    logic                  hit0, hit1, sel_hit;
    logic [1:0]            sel;

    assign off0    = addr_q - SLV0_BASE;
    assign off1    = addr_q - SLV1_BASE;
    assign hit0    = (off0 < SLV_SIZE);
    assign hit1    = !hit0 && (off1 < SLV_SIZE);
    assign sel     = {hit1, hit0};
    assign sel_hit = hit0 | hit1;

    assign paddr_o  = addr_q;
    assign pwdata_o = pwdata_q;
    assign rdata_o  = rdata_q;

    // State register; rst_n is an active-high asynchronous reset here.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state, output decode and datapath strobes.
    always_comb begin
        state_d       = state_q;
        wr_gnt_o      = 1'b0;
        rd_gnt_o      = 1'b0;
        wdata_ready_o = 1'b0;
        wr_done_o     = 1'b0;
        wr_err_o      = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_last_o  = 1'b0;
        rdata_err_o   = 1'b0;
        pwrite_o      = 1'b0;
        penable_o     = 1'b0;
        psel_o        = 2'b00;
        take_wr       = 1'b0;
        take_rd       = 1'b0;
        wbeat_load    = 1'b0;
        rd_cap        = 1'b0;
        wr_resp       = 1'b0;
        wr_resp_err   = 1'b0;
        beat_adv      = 1'b0;
        done_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so hold them off while reset is up.
                if (!rst_n && wr_req_i && (!rd_req_i || last_rd_q)) begin
                    wr_gnt_o = 1'b1;
                    take_wr  = 1'b1;
                    state_d  = WWAIT;
                end else if (!rst_n && rd_req_i) begin
                    rd_gnt_o = 1'b1;
                    take_rd  = 1'b1;
                    state_d  = SETUP;
                end
            end
            WWAIT: begin
                if (wdata_valid_i) begin
                    wdata_ready_o = 1'b1;
                    wbeat_load    = 1'b1;
                    state_d       = SETUP;
                end
            end
            SETUP: begin
                pwrite_o = dir_wr_q;
                psel_o   = sel;
                if (sel_hit) begin
                    state_d = ACCESS;
                end else if (dir_wr_q) begin
                    // Unmapped beat: no APB cycle, complete it as an error.
                    wr_resp     = 1'b1;
                    wr_resp_err = 1'b1;
                    if (cnt_q != 4'd0) begin
                        beat_adv = 1'b1;
                        state_d  = WWAIT;
                    end else begin
                        state_d  = DONE;
                    end
                end else begin
                    rd_cap  = 1'b1;
                    state_d = RHOLD;
                end
            end
            ACCESS: begin
                pwrite_o  = dir_wr_q;
                psel_o    = sel;
                penable_o = 1'b1;
                if (pready_i) begin
                    if (dir_wr_q) begin
                        wr_resp     = 1'b1;
                        wr_resp_err = pslverr_i;
                        if (cnt_q != 4'd0) begin
                            beat_adv = 1'b1;
                            state_d  = WWAIT;
                        end else begin
                            state_d  = DONE;
                        end
                    end else begin
                        rd_cap  = 1'b1;
                        state_d = RHOLD;
                    end
                end
            end
            RHOLD: begin
                rdata_valid_o = 1'b1;
                rdata_last_o  = (cnt_q == 4'd0);
                rdata_err_o   = rerr_q;
                if (rdata_ready_i) begin
                    if (cnt_q != 4'd0) begin
                        beat_adv = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            DONE: begin
                wr_done_o = 1'b1;
                wr_err_o  = werr_q;
                done_clr  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context, beat data and status registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_q    <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            cnt_q     <= 4'd0;
            incr_q    <= 1'b0;
            dir_wr_q  <= 1'b0;
            last_rd_q <= 1'b1;
            werr_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            if (take_wr || take_rd) begin
                addr_q    <= take_wr ? wr_addr_i : rd_addr_i;
                cnt_q     <= take_wr ? wr_len_i : rd_len_i;
                incr_q    <= (take_wr ? wr_burst_i : rd_burst_i) != 2'd0;
                dir_wr_q  <= take_wr;
                last_rd_q <= take_rd;
                werr_q    <= 1'b0;
            end
            if (wbeat_load) pwdata_q <= wdata_i;
            if (rd_cap) begin
                rdata_q <= sel_hit ? prdata_i : '0;
                rerr_q  <= sel_hit ? pslverr_i : 1'b1;
            end
            if (wr_resp)  werr_q <= werr_q | wr_resp_err;
            if (done_clr) werr_q <= 1'b0;
            if (beat_adv) begin
                cnt_q <= cnt_q - 4'd1;
                if (incr_q) addr_q <= addr_q + ADDR_WIDTH'(4);
            end
        end
    end

endmodule

// File: tb/tb_apb_xfer_scheduler.sv
// tb_apb_xfer_scheduler: directed bench for the AXI-to-APB burst scheduler.
module tb_apb_xfer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_req_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic [3:0]  wr_len_i = '0;
    logic [1:0]  wr_burst_i = '0;
    logic        wr_gnt_o;
    logic [31:0] wdata_i = '0;
    logic        wdata_valid_i = 1'b0;
    logic        wdata_ready_o;
    logic        wr_done_o;
    logic        wr_err_o;
    logic        rd_req_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic [3:0]  rd_len_i = '0;
    logic [1:0]  rd_burst_i = '0;
    logic        rd_gnt_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        rdata_last_o;
    logic        rdata_err_o;
    logic        rdata_ready_i = 1'b1;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        penable_o;
    logic [1:0]  psel_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b1;
    logic        pslverr_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    apb_xfer_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i),
        .wr_burst_i(wr_burst_i), .wr_gnt_o(wr_gnt_o),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wr_done_o(wr_done_o), .wr_err_o(wr_err_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
        .rd_burst_i(rd_burst_i), .rd_gnt_o(rd_gnt_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_last_o(rdata_last_o),
        .rdata_err_o(rdata_err_o), .rdata_ready_i(rdata_ready_i),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .penable_o(penable_o), .psel_o(psel_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write burst: checks every beat's handshake, APB phase signals and address,
    // stalls pready on one beat and flags pslverr on one beat.
    task automatic run_write(input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [31:0] data_base,
                             input logic [31:0] step_exp, input logic [1:0] sel_exp,
                             input int stall_beat, input int stall_n,
                             input int err_beat, input logic err_exp);
        int acc;
        wr_addr_i = addr; wr_len_i = len; wr_burst_i = burst; wr_req_i = 1'b1;
        #1 check_eq("wr_gnt", wr_gnt_o, 1'b1);
        step();
        wr_req_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata_i = data_base + 32'(b); wdata_valid_i = 1'b1;
            #1 check_eq("wdata_ready", wdata_ready_o, 1'b1);
            step();
            wdata_valid_i = 1'b0;
            #1;
            check_eq("w_setup_psel", psel_o, sel_exp);
            check_eq("w_setup_penable", penable_o, 1'b0);
            check_eq("w_pwrite", pwrite_o, 1'b1);
            check_eq("w_paddr", paddr_o, addr + 32'(b) * step_exp);
            check_eq("w_pwdata", pwdata_o, data_base + 32'(b));
            acc = 0;
            if (sel_exp != 2'b00) begin
                step();
                while (acc < 20) begin
                    pready_i  = !(b == stall_beat && acc < stall_n);
                    pslverr_i = (b == err_beat);
                    #1;
                    check_eq("w_access_penable", penable_o, 1'b1);
                    check_eq("w_access_psel", psel_o, sel_exp);
                    acc++;
                    step();
                    if (pready_i) break;
                end
                check_eq("w_access_cycles", acc, (b == stall_beat) ? stall_n + 1 : 1);
            end else begin
                step();
            end
            pready_i = 1'b1; pslverr_i = 1'b0;
        end
        #1;
        check_eq("wr_done", wr_done_o, 1'b1);
        check_eq("wr_err", wr_err_o, err_exp);
        check_eq("done_psel", psel_o, 2'b00);
        step();
        #1 check_eq("wr_done_pulse", wr_done_o, 1'b0);
    endtask

    // Read burst: per-beat APB checks and front-end presentation with an
    // optional rdata_ready back-pressure on one beat.
    task automatic run_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [31:0] data_base,
                            input logic [31:0] step_exp, input logic [1:0] sel_exp,
                            input int stall_beat, input int stall_n);
        int held;
        rd_addr_i = addr; rd_len_i = len; rd_burst_i = burst; rd_req_i = 1'b1;
        #1 check_eq("rd_gnt", {wr_gnt_o, rd_gnt_o}, 2'b01);
        step();
        rd_req_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            #1;
            check_eq("r_setup_psel", psel_o, sel_exp);
            check_eq("r_setup_penable", penable_o, 1'b0);
            check_eq("r_pwrite", pwrite_o, 1'b0);
            check_eq("r_paddr", paddr_o, addr + 32'(b) * step_exp);
            if (sel_exp != 2'b00) begin
                step();
                prdata_i = data_base + 32'(b); pready_i = 1'b1; pslverr_i = 1'b0;
                #1 check_eq("r_access_penable", penable_o, 1'b1);
            end
            step();
            held = 0;
            while (held < 20) begin
                rdata_ready_i = !(b == stall_beat && held < stall_n);
                #1;
                check_eq("r_valid", rdata_valid_o, 1'b1);
                check_eq("r_data", rdata_o, (sel_exp != 2'b00) ? data_base + 32'(b) : 32'h0);
                check_eq("r_last", rdata_last_o, b == int'(len));
                check_eq("r_err", rdata_err_o, sel_exp == 2'b00);
                held++;
                step();
                if (rdata_ready_i) break;
            end
            check_eq("r_hold_cycles", held, (b == stall_beat) ? stall_n + 1 : 1);
        end
        rdata_ready_i = 1'b1;
        #1 check_eq("r_idle_valid", rdata_valid_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {wr_gnt_o, rd_gnt_o, wdata_ready_o, wr_done_o, wr_err_o,
                                  rdata_valid_o, rdata_last_o, rdata_err_o,
                                  pwrite_o, penable_o, psel_o}, 12'h0);
        check_eq({tag, "_paddr"}, paddr_o, 32'h0);
        check_eq({tag, "_pwdata"}, pwdata_o, 32'h0);
        check_eq({tag, "_rdata"}, rdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ng;
        int cyc;
        int ndone;
        logic [1:0] g;

        // Reset held with a write request pending: no grant may escape.
        wr_req_i = 1'b1; wr_addr_i = 32'h0001_F010;
        step(); step();
        check_all_zero("reset");
        wr_req_i = 1'b0;
        rst_n = 1'b0;
        step();

        run_write(32'h0001_F010, 4'd0, 2'd1, 32'hDEAD_BEEF, 32'd4, 2'b01, -1, 0, -1, 1'b0);
        run_read (32'h0002_F000, 4'd3, 2'd1, 32'h1111_0000, 32'd4, 2'b10, 1, 2);
        run_write(32'h0001_F100, 4'd3, 2'd0, 32'h5A5A_0000, 32'd0, 2'b01, -1, 0, -1, 1'b0);
        run_write(32'h0001_F200, 4'd2, 2'd1, 32'h7700_0000, 32'd4, 2'b01, 1, 5, 1, 1'b1);
        run_read (32'h0003_0000, 4'd1, 2'd1, 32'hBBBB_0000, 32'd4, 2'b00, -1, 0);
        run_read (32'h0001_F040, 4'd0, 2'd0, 32'hCAFE_F00D, 32'd0, 2'b01, -1, 0);

        // Reset in the middle of a write burst's ACCESS phase.
        wr_addr_i = 32'h0001_F000; wr_len_i = 4'd3; wr_burst_i = 2'd1; wr_req_i = 1'b1;
        wdata_i = 32'h1234_5678; wdata_valid_i = 1'b1;
        #1 check_eq("rst_wr_gnt", wr_gnt_o, 1'b1);
        step();
        wr_req_i = 1'b0;
        step();
        pready_i = 1'b0;
        step();
        #1 check_eq("rst_pre_penable", penable_o, 1'b1);
        rst_n = 1'b1;
        #1 check_all_zero("midrst");
        step();
        check_all_zero("midrst_edge");
        rst_n = 1'b0; wdata_valid_i = 1'b0; pready_i = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            #1 if (wr_done_o) ndone++;
            step();
        end
        check_eq("abandon_no_done", ndone, 0);

        // Both requests held: grants must alternate starting with write.
        wr_addr_i = 32'h0001_F000; wr_len_i = 4'd0; wr_burst_i = 2'd1;
        rd_addr_i = 32'h0002_F000; rd_len_i = 4'd0; rd_burst_i = 2'd1;
        wdata_valid_i = 1'b1; rdata_ready_i = 1'b1; pready_i = 1'b1; prdata_i = 32'h0000_00AA;
        wr_req_i = 1'b1; rd_req_i = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 100) begin
            #1;
            g = {wr_gnt_o, rd_gnt_o};
            if (g != 2'b00) begin
                check_eq($sformatf("arb_gnt%0d", ng), g, (ng % 2 == 0) ? 2'b10 : 2'b01);
                ng++;
                if (ng == 4) begin
                    wr_req_i = 1'b0; rd_req_i = 1'b0;
                end
            end
            cyc++;
            step();
        end
        check_eq("arb_grant_count", ng, 4);
        for (int i = 0; i < 6; i++) step();
        #1 check_eq("arb_idle", {rdata_valid_o, penable_o, psel_o}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_xfer_scheduler.md
# apb_xfer_scheduler

Sequencing and arbitration core of the AXI-to-APB bridge: it accepts one pending write burst and one pending read burst from the AXI front-end buffers, grants them round-robin onto the single APB master port, and walks each burst beat-by-beat through APB SETUP/ACCESS phases. It generates per-beat addresses (FIXED/INCR), decodes them to the two 4 KB slave regions (psel_o[1:0]), and returns per-beat read data and per-burst write status to the front-end.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SLV0_BASE, 32'h0001_F000, slave 0 region start
- SLV1_BASE, 32'h0002_F000, slave 1 region start
- SLV_SIZE, 32'h0000_1000, size of each region (power of two)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high
- wr_req_i  in  1  write burst pending; held until wr_gnt_o
- wr_addr_i / wr_len_i / wr_burst_i  in  ADDR_WIDTH / 4 / 2  start address, beats-1, burst type; stable while wr_req_i
- wr_gnt_o  out  1  one-cycle pulse: write burst accepted
- wdata_i  in  DATA_WIDTH  write beat data
- wdata_valid_i  in  1  wdata_i valid
- wdata_ready_o  out  1  one-cycle pulse: beat consumed
- wr_done_o  out  1  one-cycle pulse: write burst complete
- wr_err_o  out  1  valid with wr_done_o: any beat errored
- rd_req_i / rd_addr_i / rd_len_i / rd_burst_i  in  1 / ADDR_WIDTH / 4 / 2  read burst request, same rules as write
- rd_gnt_o  out  1  one-cycle pulse: read burst accepted
- rdata_o  out  DATA_WIDTH  read beat data
- rdata_valid_o / rdata_last_o / rdata_err_o  out  1  beat valid, last beat, beat error
- rdata_ready_i  in  1  front-end accepts beat
- paddr_o / pwdata_o  out  ADDR_WIDTH / DATA_WIDTH  APB address / write data
- pwrite_o / penable_o  out  1  APB direction / access phase
- psel_o  out  2  one-hot slave select (bit0 = slave 0)
- prdata_i / pready_i / pslverr_i  in  DATA_WIDTH / 1 / 1  APB slave response (already muxed)

## Operation
- States: IDLE, WWAIT, SETUP, ACCESS, RHOLD, DONE.
- IDLE: if only one request, grant it; if both, grant the type not served last. last_served resets to READ (write wins first tie). Grant latches addr, len, burst, direction; beat counter = len.
- Write grant -> WWAIT; read grant -> SETUP.
- WWAIT: when wdata_valid_i, latch pwdata_o, pulse wdata_ready_o, -> SETUP.
- SETUP: drive paddr_o, pwrite_o, decoded psel_o, penable_o=0; -> ACCESS.
- ACCESS: penable_o=1 until pready_i=1. On pready_i: read -> capture prdata_i/pslverr_i, -> RHOLD; write -> OR pslverr_i into error flag, -> WWAIT if beats remain, else DONE.
- RHOLD: rdata_valid_o=1 (rdata_last_o when counter=0) until rdata_ready_i; then -> SETUP if beats remain, else IDLE.
- DONE: wr_done_o=1, wr_err_o=flag for one cycle; -> IDLE; flag cleared.
- Address: INCR (1) adds 4 after each beat; FIXED (0) holds; types 2/3 treated as INCR. Address wraps modulo 2^ADDR_WIDTH.
- Decode per beat: [SLV0_BASE, SLV0_BASE+SLV_SIZE) -> psel_o=01; [SLV1_BASE, +SLV_SIZE) -> 10; otherwise no APB transfer: SETUP goes directly to completion handling with error=1, prdata=0, psel_o=00.
- psel_o never has both bits set.

## Timing
- Reset: all outputs 0, state IDLE, counter/flags cleared, last_served=READ; a reset mid-burst abandons it without wr_done_o.
- wr_gnt_o/rd_gnt_o assert in the IDLE cycle the request is sampled.
- Write beat minimum 3 cycles (WWAIT, SETUP, ACCESS); each pready_i=0 cycle adds one.
- Read beat minimum 3 cycles (SETUP, ACCESS, RHOLD); each rdata_ready_i=0 cycle adds one.
- paddr_o/pwrite_o/psel_o/pwdata_o stable from SETUP through final ACCESS cycle; psel_o deasserts after ACCESS.
- New grant is possible in the cycle after DONE or the final RHOLD handshake.

## Test plan
- Single write, addr 0x0001_F010, len 0, data 0xDEADBEEF, pready 1 -> psel=01 for 2 cycles, pwdata=DEADBEEF, wr_done_o 1 cycle later, wr_err_o=0.
- INCR read 0x0002_F000, len 3, rdata_ready 1 -> paddr 2F000/2F004/2F008/2F00C, psel=10, rdata_last_o only on 4th beat.
- FIXED write len 3 to 0x0001_F100 -> paddr stays 0x0001_F100 for all 4 beats, 4 wdata_ready_o pulses.
- wr_req and rd_req together after reset, repeated -> grants alternate W, R, W, R.
- pready held 0 for 5 cycles and pslverr=1 on beat 2 of 3-beat write -> penable held 6 cycles, wr_err_o=1.
- Read at 0x0003_0000 -> psel=00, rdata_err_o=1, rdata_o=0; rst_n asserted mid-burst -> all outputs 0 next edge.
